// File: rtl/stereo_stream_gen_pkg.sv
// Shared constants, FSM state type and texture function for the stereo stream generator.
// Checkers may reuse texture() to predict pixel values.
package stereo_stream_gen_pkg;

    localparam int DEF_H_FP   = 4;
    localparam int DEF_H_SYNC = 8;
    localparam int DEF_H_BP   = 4;
    localparam int DEF_V_FP   = 2;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 2;

    localparam logic [7:0] TEX_MUL = 8'd29;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } gen_state_e;

    // An odd multiplier keeps T a bijection of x within a row.
    function automatic logic [7:0] texture(input logic [7:0] x, input logic [5:0] y);
        return (x ^ {y, 2'b00}) * TEX_MUL;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters, IDLE/RUN FSM and de/sync decode for the stereo stream generator.
module video_timing_gen
    import stereo_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = 64,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int H_W     = $clog2(H_TOTAL),
    localparam int V_W     = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           de,
    output logic           hsync,
    output logic           vsync,
    output logic           frame_last,
    output logic           frame_first
);

    // One extra bit so decode bounds equal to the total cannot overflow.
    localparam logic [H_W:0] HA_END = (H_W + 1)'(H_ACTIVE);
    localparam logic [H_W:0] HS_BEG = (H_W + 1)'(H_ACTIVE + H_FP);
    localparam logic [H_W:0] HS_END = (H_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W:0] VA_END = (V_W + 1)'(V_ACTIVE);
    localparam logic [V_W:0] VS_BEG = (V_W + 1)'(V_ACTIVE + V_FP);
    localparam logic [V_W:0] VS_END = (V_W + 1)'(V_ACTIVE + V_FP + V_SYNC);

    gen_state_e     state;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           running;
    logic           h_last;
    logic           v_last;

    assign running = (state == ST_RUN);
    assign h_last  = (h_cnt == H_W'(H_TOTAL - 1));
    assign v_last  = (v_cnt == V_W'(V_TOTAL - 1));

    // Stopping is only honoured on the final cycle so a frame is never truncated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (enable) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        if (v_last) begin
                            v_cnt <= '0;
                            if (!enable) state <= ST_IDLE;
                        end else begin
                            v_cnt <= v_cnt + 1'b1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign x           = h_cnt;
    assign y           = v_cnt;
    assign de          = running && ({1'b0, h_cnt} < HA_END) && ({1'b0, v_cnt} < VA_END);
    assign hsync       = running && ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
    assign vsync       = running && ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
    assign frame_last  = running && h_last && v_last;
    assign frame_first = running && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/stereo_stream_gen.sv
// Synthetic stereo source: right image is the left texture shifted by cur_disp.
// Define STEREO_GEN_DISP_SWEEP_EN to step cur_disp through the disparity range each frame.
module stereo_stream_gen
    import stereo_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE        = 64,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = 64,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int DISPARITY_RANGE = 8,
    parameter int TRUE_DISP       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [7:0]  pixel_left,
    output logic [7:0]  pixel_right,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic [7:0]  cur_disp
);

    localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [H_W-1:0] x;
    logic [V_W-1:0] y;
    logic           de;
    logic           hsync;
    logic           vsync;
    logic           frame_last;
    logic           frame_first;
    logic [7:0]     x8;
    logic [7:0]     x_shift;
    logic [5:0]     y6;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .x           (x),
        .y           (y),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_last  (frame_last),
        .frame_first (frame_first)
    );

    // An 8-bit wrapping add yields exactly the low byte of the 9-bit x+d.
    assign x8      = 8'(x);
    assign y6      = 6'(y);
    assign x_shift = x8 + cur_disp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out      <= 1'b0;
            h_sync_out  <= 1'b0;
            v_sync_out  <= 1'b0;
            pixel_left  <= '0;
            pixel_right <= '0;
            frame_start <= 1'b0;
            frame_count <= '0;
            cur_disp    <= 8'(TRUE_DISP);
        end else begin
            de_out      <= de;
            h_sync_out  <= hsync;
            v_sync_out  <= vsync;
            frame_start <= frame_first;
            pixel_left  <= de ? texture(x8, y6) : 8'd0;
            pixel_right <= de ? texture(x_shift, y6) : 8'd0;
            if (frame_last) begin
                frame_count <= frame_count + 16'd1;
`ifdef STEREO_GEN_DISP_SWEEP_EN
                cur_disp <= (cur_disp == 8'(DISPARITY_RANGE - 1)) ? 8'd0 : cur_disp + 8'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_stereo_stream_gen.sv
// Directed self-checking bench for stereo_stream_gen with default geometry (80 x 70 raster).
module tb_stereo_stream_gen;

    localparam int H_TOTAL = 80;
    localparam int V_TOTAL = 70;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
`ifdef STEREO_GEN_DISP_SWEEP_EN
    localparam bit SWEEP          = 1'b1;
    localparam int RESTART_FRAMES = 8;
`else
    localparam bit SWEEP          = 1'b0;
    localparam int RESTART_FRAMES = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [7:0]  pixel_left;
    logic [7:0]  pixel_right;
    logic        frame_start;
    logic [15:0] frame_count;
    logic [7:0]  cur_disp;

    int vectors;
    int miscompares;

    // Hand-computed row 0 of the texture: 29*x mod 256 for x = 0..8.
    logic [7:0] row0 [0:8] = '{8'd0, 8'd29, 8'd58, 8'd87, 8'd116, 8'd145, 8'd174, 8'd203, 8'd232};

    stereo_stream_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .de_out      (de_out),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .pixel_left  (pixel_left),
        .pixel_right (pixel_right),
        .frame_start (frame_start),
        .frame_count (frame_count),
        .cur_disp    (cur_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic en_v);
        rst_n  = rst_v;
        enable = en_v;
        @(negedge clk);
    endtask

    function automatic int expDisp(input int idx);
        return SWEEP ? (5 + idx) % 8 : 5;
    endfunction

    // Called on the negedge showing output (0,0); returns on the negedge after the frame.
    task automatic runFrame(input string name, input int d, input int drop_at, input int fc_exp);
        int de_cnt, de_err, hs_err, vs_err, fs_err, blank_err, pair_err;
        logic [7:0] lb [0:63];
        logic [7:0] rb [0:63];
        de_cnt = 0; de_err = 0; hs_err = 0; vs_err = 0; fs_err = 0; blank_err = 0; pair_err = 0;
        for (int k = 0; k < FRAME; k++) begin
            int  x;
            int  y;
            logic exp_de;
            x      = k % H_TOTAL;
            y      = k / H_TOTAL;
            exp_de = (x < 64) && (y < 64);
            if (k == drop_at) enable = 1'b0;
            if (de_out) de_cnt++;
            if (de_out != exp_de) de_err++;
            if (h_sync_out != ((x >= 68) && (x < 76))) hs_err++;
            if (v_sync_out != ((y >= 66) && (y < 68))) vs_err++;
            if (frame_start != (k == 0)) fs_err++;
            if (!exp_de && (pixel_left != 8'd0 || pixel_right != 8'd0)) blank_err++;
            if (exp_de) begin
                lb[x] = pixel_left;
                rb[x] = pixel_right;
                if (x == 63)
                    for (int i = 0; i < 64 - d; i++)
                        if (rb[i] != lb[i + d]) pair_err++;
            end
            if (k == 0) begin
                checkOutput({name, " first left"}, 32'(pixel_left), 32'd0);
                checkOutput({name, " first right"}, 32'(pixel_right), 32'(row0[d]));
                checkOutput({name, " cur_disp"}, 32'(cur_disp), 32'(d));
                checkOutput({name, " frame_count"}, 32'(frame_count), 32'(fc_exp));
            end
            if (k == 1) begin
                checkOutput({name, " second left"}, 32'(pixel_left), 32'd29);
                checkOutput({name, " second right"}, 32'(pixel_right), 32'(row0[d + 1]));
            end
            if (k == H_TOTAL) checkOutput({name, " line1 left"}, 32'(pixel_left), 32'd116);
            @(negedge clk);
        end
        checkOutput({name, " de count"}, 32'(de_cnt), 32'd4096);
        checkOutput({name, " de placement"}, 32'(de_err), 32'd0);
        checkOutput({name, " hsync window"}, 32'(hs_err), 32'd0);
        checkOutput({name, " vsync window"}, 32'(vs_err), 32'd0);
        checkOutput({name, " frame_start"}, 32'(fs_err), 32'd0);
        checkOutput({name, " blank pixels"}, 32'(blank_err), 32'd0);
        checkOutput({name, " right=left shifted"}, 32'(pair_err), 32'd0);
    endtask

    task automatic checkIdle(input string name, input int cycles, input int fc_exp);
        int busy;
        busy = 0;
        for (int i = 0; i < cycles; i++) begin
            if (de_out || h_sync_out || v_sync_out || frame_start ||
                pixel_left != 8'd0 || pixel_right != 8'd0) busy++;
            @(negedge clk);
        end
        checkOutput({name, " outputs quiet"}, 32'(busy), 32'd0);
        checkOutput({name, " frame_count"}, 32'(frame_count), 32'(fc_exp));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset de_out", 32'(de_out), 32'd0);
        checkOutput("reset syncs", 32'({h_sync_out, v_sync_out, frame_start}), 32'd0);
        checkOutput("reset pixels", 32'({pixel_left, pixel_right}), 32'd0);
        checkOutput("reset frame_count", 32'(frame_count), 32'd0);
        checkOutput("reset cur_disp", 32'(cur_disp), 32'd5);

        applyStimulus(1'b1, 1'b0);
        checkIdle("idle before enable", 10, 0);

        // Enable at this negedge: de_out must still be low one cycle later.
        applyStimulus(1'b1, 1'b1);
        checkOutput("start latency", 32'(de_out), 32'd0);
        @(negedge clk);
        runFrame("frameA", expDisp(0), 10 * H_TOTAL, 0);
        checkIdle("idle after drop", 20, 1);

        applyStimulus(1'b1, 1'b1);
        checkOutput("restart latency", 32'(de_out), 32'd0);
        @(negedge clk);
        runFrame("frameB", expDisp(1), -1, 1);

        repeat (100) @(negedge clk);
        checkOutput("pre-reset de_out", 32'(de_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset de_out", 32'(de_out), 32'd0);
        checkOutput("async reset pixels", 32'({pixel_left, pixel_right}), 32'd0);
        checkOutput("async reset frame_count", 32'(frame_count), 32'd0);
        checkOutput("async reset cur_disp", 32'(cur_disp), 32'd5);
        @(negedge clk);

        applyStimulus(1'b1, 1'b1);
        checkOutput("post-reset latency", 32'(de_out), 32'd0);
        @(negedge clk);
        for (int i = 0; i < RESTART_FRAMES; i++)
            runFrame($sformatf("restart%0d", i), expDisp(i),
                     (i == RESTART_FRAMES - 1) ? 10 * H_TOTAL : -1, i);
        checkIdle("final idle", 20, RESTART_FRAMES);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
